// File: rtl/ex_brchslv_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_brchslv_reg_pkg
// Description : Shared types and constants for the branch-resolve stage
// Revision    : 1.0  initial release
// ============================================================================
package ex_brchslv_reg_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam int unsigned c_INC4 = 4;
    localparam int unsigned c_INC2 = 2;

    typedef logic [3:0] flush_type_t;

    localparam flush_type_t c_TYPE_MRET    = 4'b0001;
    localparam flush_type_t c_TYPE_DRET    = 4'b0010;
    localparam flush_type_t c_TYPE_FENCEI  = 4'b0100;
    localparam flush_type_t c_TYPE_MISPRED = 4'b1000;

    // Same priority as the target mux so the ena pulse matches the chosen PC.
    function automatic flush_type_t flush_type_f(input logic dret, input logic mret,
                                                 input logic fencei);
        if (dret)        return c_TYPE_DRET;
        else if (mret)   return c_TYPE_MRET;
        else if (fencei) return c_TYPE_FENCEI;
        else             return c_TYPE_MISPRED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_brchslv_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_brchslv_reg_if
// Description : Commit and flush handshake bundle of the branch-resolve stage
// Revision    : 1.0  initial release
// ============================================================================
interface ex_brchslv_reg_if #(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32
);
    logic               cmt_i_valid;
    logic               cmt_i_ready;
    logic               cmt_i_rv32;
    logic               cmt_i_dret;
    logic               cmt_i_mret;
    logic               cmt_i_fencei;
    logic               cmt_i_bjp;
    logic               cmt_i_bjp_prdt;
    logic               cmt_i_bjp_rslv;
    logic [PC_SIZE-1:0] cmt_i_pc;
    logic [XLEN-1:0]    cmt_i_imm;
    logic [PC_SIZE-1:0] csr_epc_r;
    logic [PC_SIZE-1:0] csr_dpc_r;
    logic               nonalu_excpirq_flush_req_raw;
    logic               brchmis_flush_req;
    logic               brchmis_flush_ack;
    logic [PC_SIZE-1:0] brchmis_flush_pc;
    logic               cmt_mret_ena;
    logic               cmt_dret_ena;
    logic               cmt_fencei_ena;

    modport master (
        output cmt_i_valid, cmt_i_rv32, cmt_i_dret, cmt_i_mret, cmt_i_fencei,
               cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv, cmt_i_pc, cmt_i_imm,
               csr_epc_r, csr_dpc_r, nonalu_excpirq_flush_req_raw, brchmis_flush_ack,
        input  cmt_i_ready, brchmis_flush_req, brchmis_flush_pc,
               cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena
    );

    modport slave (
        input  cmt_i_valid, cmt_i_rv32, cmt_i_dret, cmt_i_mret, cmt_i_fencei,
               cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv, cmt_i_pc, cmt_i_imm,
               csr_epc_r, csr_dpc_r, nonalu_excpirq_flush_req_raw, brchmis_flush_ack,
        output cmt_i_ready, brchmis_flush_req, brchmis_flush_pc,
               cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena
    );
endinterface
`default_nettype wire

// File: rtl/ex_brchslv_satcnt.sv
`default_nettype none
// ============================================================================
// Module      : ex_brchslv_satcnt
// Description : Saturating up-counter with synchronous clear
// Revision    : 1.0  initial release
// ============================================================================
module ex_brchslv_satcnt #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ex_brchslv_tgt.sv
`default_nettype none
// ============================================================================
// Module      : ex_brchslv_tgt
// Description : Flush target PC selection (CSR, sequential or branch target)
// Revision    : 1.0  initial release
// ============================================================================
module ex_brchslv_tgt
    import ex_brchslv_reg_pkg::*;
#(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32,
    parameter bit RVC_EN  = 1'b1
) (
    input  wire logic               i_rv32,
    input  wire logic               i_dret,
    input  wire logic               i_mret,
    input  wire logic               i_fencei,
    input  wire logic               i_prdt,
    input  wire logic [PC_SIZE-1:0] i_pc,
    input  wire logic [XLEN-1:0]    i_imm,
    input  wire logic [PC_SIZE-1:0] i_epc,
    input  wire logic [PC_SIZE-1:0] i_dpc,
    output logic      [PC_SIZE-1:0] o_tgt
);
    logic [PC_SIZE-1:0] w_inc;
    logic [PC_SIZE-1:0] w_seq_pc;
    logic [PC_SIZE-1:0] w_br_pc;

    assign w_inc    = (i_rv32 || !RVC_EN) ? PC_SIZE'(c_INC4) : PC_SIZE'(c_INC2);
    assign w_seq_pc = i_pc + w_inc;
    assign w_br_pc  = i_pc + i_imm[PC_SIZE-1:0];

    // A predicted-taken bjp that resolves not-taken restarts at the next instruction.
    always_comb begin
        o_tgt = w_br_pc;
        if (i_dret)
            o_tgt = i_dpc;
        else if (i_mret)
            o_tgt = i_epc;
        else if (i_fencei || i_prdt)
            o_tgt = w_seq_pc;
    end

endmodule
`default_nettype wire

// File: rtl/ex_brchslv_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_brchslv_reg
// Description : Registered branch-resolve / flush-request stage with counters
// Revision    : 1.0  initial release
// ============================================================================
module ex_brchslv_reg
    import ex_brchslv_reg_pkg::*;
#(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32,
    parameter bit RVC_EN  = 1'b1,
    parameter int CNT_W   = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    ex_brchslv_reg_if.slave   bus,
    input  wire logic         cnt_clr,
    output logic [CNT_W-1:0]  mispred_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              busy
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_SIZE-1:0] r_flush_pc;
    flush_type_t        r_type;

    logic               w_raw;
    logic               w_is_branch;
    logic               w_need_flush;
    logic               w_ready;
    logic               w_req;
    logic               w_cap;
    logic               w_hsk;
    logic [PC_SIZE-1:0] w_tgt;

    assign w_raw        = bus.nonalu_excpirq_flush_req_raw;
    assign w_is_branch  = bus.cmt_i_bjp | bus.cmt_i_fencei | bus.cmt_i_mret | bus.cmt_i_dret;
    assign w_need_flush = (bus.cmt_i_bjp & (bus.cmt_i_bjp_prdt ^ bus.cmt_i_bjp_rslv))
                        | bus.cmt_i_fencei | bus.cmt_i_mret | bus.cmt_i_dret;

    ex_brchslv_tgt #(
        .PC_SIZE (PC_SIZE),
        .XLEN    (XLEN),
        .RVC_EN  (RVC_EN)
    ) u_tgt (
        .i_rv32   (bus.cmt_i_rv32),
        .i_dret   (bus.cmt_i_dret),
        .i_mret   (bus.cmt_i_mret),
        .i_fencei (bus.cmt_i_fencei),
        .i_prdt   (bus.cmt_i_bjp_prdt),
        .i_pc     (bus.cmt_i_pc),
        .i_imm    (bus.cmt_i_imm),
        .i_epc    (bus.csr_epc_r),
        .i_dpc    (bus.csr_dpc_r),
        .o_tgt    (w_tgt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Branch commits stall while a higher-priority flush is pending so they
    // are not retired underneath the exception/IRQ flush.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_req       = 1'b0;
        w_cap       = 1'b0;
        w_hsk       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~w_is_branch | ~w_raw;
                w_cap   = bus.cmt_i_valid & w_ready & w_need_flush;
                if (w_cap)
                    w_state_nxt = REQ;
            end
            REQ: begin
                w_req = ~w_raw;
                w_hsk = w_req & bus.brchmis_flush_ack;
                if (w_hsk)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_pc <= '0;
            r_type     <= '0;
        end else if (w_cap) begin
            r_flush_pc <= w_tgt;
            r_type     <= flush_type_f(bus.cmt_i_dret, bus.cmt_i_mret, bus.cmt_i_fencei);
        end
    end

    assign bus.cmt_i_ready       = w_ready;
    assign bus.brchmis_flush_req = w_req;
    assign bus.brchmis_flush_pc  = r_flush_pc;
    assign bus.cmt_mret_ena      = w_hsk & (r_type == c_TYPE_MRET);
    assign bus.cmt_dret_ena      = w_hsk & (r_type == c_TYPE_DRET);
    assign bus.cmt_fencei_ena    = w_hsk & (r_type == c_TYPE_FENCEI);
    assign busy                  = (r_state == REQ);

    ex_brchslv_satcnt #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (cnt_clr),
        .i_inc (w_hsk & (r_type == c_TYPE_MISPRED)),
        .o_cnt (mispred_cnt)
    );

    ex_brchslv_satcnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (cnt_clr),
        .i_inc (w_hsk),
        .o_cnt (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_ex_brchslv_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_brchslv_reg
// Description : Directed scoreboard bench for ex_brchslv_reg (RVC_EN=1 and 0)
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_brchslv_reg;
    localparam int PC_SIZE = 32;
    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;

    logic clk;
    logic rst_n;
    logic cnt_clr;
    logic [CNT_W-1:0] mispred_cnt, flush_cnt, mispred_cnt2, flush_cnt2;
    logic busy, busy2;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc2;
        logic [2:0]  ena;   // {fencei, dret, mret}
    } exp_t;
    exp_t sb[$];

    ex_brchslv_reg_if #(.PC_SIZE(PC_SIZE), .XLEN(XLEN)) bus  ();
    ex_brchslv_reg_if #(.PC_SIZE(PC_SIZE), .XLEN(XLEN)) bus2 ();

    ex_brchslv_reg #(.PC_SIZE(PC_SIZE), .XLEN(XLEN), .RVC_EN(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr),
        .mispred_cnt(mispred_cnt), .flush_cnt(flush_cnt), .busy(busy)
    );

    ex_brchslv_reg #(.PC_SIZE(PC_SIZE), .XLEN(XLEN), .RVC_EN(1'b0), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_clr(cnt_clr),
        .mispred_cnt(mispred_cnt2), .flush_cnt(flush_cnt2), .busy(busy2)
    );

    // The RVC_EN=0 instance sees exactly the same stimulus.
    assign bus2.cmt_i_valid                  = bus.cmt_i_valid;
    assign bus2.cmt_i_rv32                   = bus.cmt_i_rv32;
    assign bus2.cmt_i_dret                   = bus.cmt_i_dret;
    assign bus2.cmt_i_mret                   = bus.cmt_i_mret;
    assign bus2.cmt_i_fencei                 = bus.cmt_i_fencei;
    assign bus2.cmt_i_bjp                    = bus.cmt_i_bjp;
    assign bus2.cmt_i_bjp_prdt               = bus.cmt_i_bjp_prdt;
    assign bus2.cmt_i_bjp_rslv               = bus.cmt_i_bjp_rslv;
    assign bus2.cmt_i_pc                     = bus.cmt_i_pc;
    assign bus2.cmt_i_imm                    = bus.cmt_i_imm;
    assign bus2.csr_epc_r                    = bus.csr_epc_r;
    assign bus2.csr_dpc_r                    = bus.csr_dpc_r;
    assign bus2.nonalu_excpirq_flush_req_raw = bus.nonalu_excpirq_flush_req_raw;
    assign bus2.brchmis_flush_ack            = bus.brchmis_flush_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] enas();
        return {bus.cmt_fencei_ena, bus.cmt_dret_ena, bus.cmt_mret_ena};
    endfunction

    function automatic logic [2:0] enas2();
        return {bus2.cmt_fencei_ena, bus2.cmt_dret_ena, bus2.cmt_mret_ena};
    endfunction

    // f = {rv32, dret, mret, fencei, bjp, prdt, rslv}
    task automatic set_fields(input logic [6:0] f, input logic [31:0] pc, input logic [31:0] imm);
        {bus.cmt_i_rv32, bus.cmt_i_dret, bus.cmt_i_mret, bus.cmt_i_fencei,
         bus.cmt_i_bjp, bus.cmt_i_bjp_prdt, bus.cmt_i_bjp_rslv} = f;
        bus.cmt_i_pc  = pc;
        bus.cmt_i_imm = imm;
    endtask

    task automatic commit(input logic [6:0] f, input logic [31:0] pc, input logic [31:0] imm,
                          input logic exp_flush, input logic [31:0] epc1,
                          input logic [31:0] epc2, input logic [2:0] eena);
        @(negedge clk);
        set_fields(f, pc, imm);
        bus.cmt_i_valid = 1'b1;
        #1 chk("cmt_ready", bus.cmt_i_ready, 1'b1);
        if (exp_flush) sb.push_back('{pc: epc1, pc2: epc2, ena: eena});
        @(posedge clk);
        #1;
        bus.cmt_i_valid = 1'b0;
        set_fields(7'd0, 32'd0, 32'd0);
        chk("busy_after_commit", busy, exp_flush);
        chk("req_after_commit", bus.brchmis_flush_req, exp_flush);
    endtask

    // Entered one time unit after the capture edge.
    task automatic ack_flush(input int hold, input logic clr);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_empty observed=0 expected=1 entries");
            return;
        end
        e = sb.pop_front();
        chk("flush_pc", bus.brchmis_flush_pc, e.pc);
        chk("flush_pc_rvc0", bus2.brchmis_flush_pc, e.pc2);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("req_held", bus.brchmis_flush_req, 1'b1);
            chk("flush_pc_stable", bus.brchmis_flush_pc, e.pc);
        end
        bus.brchmis_flush_ack = 1'b1;
        cnt_clr = clr;
        #1;
        chk("ena_pulse", enas(), e.ena);
        chk("ena_pulse_rvc0", enas2(), e.ena);
        chk("ready_in_req", bus.cmt_i_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.brchmis_flush_ack = 1'b0;
        cnt_clr = 1'b0;
        chk("busy_after_ack", busy, 1'b0);
        chk("req_after_ack", bus2.brchmis_flush_req, 1'b0);
        chk("ena_after_ack", enas(), 3'b000);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bus.cmt_i_valid = 1'b0;
        set_fields(7'd0, 32'd0, 32'd0);
        bus.csr_epc_r = 32'h80;
        bus.csr_dpc_r = 32'h800;
        bus.nonalu_excpirq_flush_req_raw = 1'b0;
        bus.brchmis_flush_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", bus.brchmis_flush_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flush_pc", bus.brchmis_flush_pc, 32'h0);
        chk("rst_ready", bus.cmt_i_ready, 1'b1);
        chk("rst_ena", enas(), 3'b000);
        chk("rst_mispred_cnt", mispred_cnt, 4'h0);
        chk("rst_flush_cnt", flush_cnt, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mispredicted taken branch, acked two cycles after req rises.
        commit(7'b1_000_101, 32'h1000, 32'h40, 1'b1, 32'h1040, 32'h1040, 3'b000);
        ack_flush(2, 1'b0);
        chk("t1_mispred_cnt", mispred_cnt, 4'd1);
        chk("t1_flush_cnt", flush_cnt, 4'd1);

        // Predicted taken, resolved not-taken, 16-bit instruction.
        commit(7'b0_000_110, 32'h2002, 32'h100, 1'b1, 32'h2004, 32'h2006, 3'b000);
        ack_flush(0, 1'b0);
        chk("t2_mispred_cnt", mispred_cnt, 4'd2);

        // dret wins over mret; dpc sampled only at capture.
        commit(7'b1_110_000, 32'h3000, 32'h0, 1'b1, 32'h800, 32'h800, 3'b010);
        bus.csr_dpc_r = 32'h900;
        ack_flush(1, 1'b0);
        bus.csr_dpc_r = 32'h800;
        chk("t3_flush_cnt", flush_cnt, 4'd3);
        chk("t3_mispred_cnt", mispred_cnt, 4'd2);

        // raw blocks branch commits in IDLE but not plain ones.
        @(negedge clk);
        bus.nonalu_excpirq_flush_req_raw = 1'b1;
        set_fields(7'b1_000_100, 32'h0, 32'h0);
        #1 chk("raw_ready_branch", bus.cmt_i_ready, 1'b0);
        set_fields(7'b1_000_000, 32'h0, 32'h0);
        #1 chk("raw_ready_nonbranch", bus.cmt_i_ready, 1'b1);
        bus.nonalu_excpirq_flush_req_raw = 1'b0;

        // raw during REQ masks req and ignores ack.
        commit(7'b1_001_000, 32'h3000, 32'h0, 1'b1, 32'h3004, 32'h3004, 3'b100);
        e = sb.pop_front();
        chk("t4_flush_pc", bus.brchmis_flush_pc, e.pc);
        bus.nonalu_excpirq_flush_req_raw = 1'b1;
        bus.brchmis_flush_ack = 1'b1;
        repeat (3) begin
            #1;
            chk("t4_req_masked", bus.brchmis_flush_req, 1'b0);
            chk("t4_no_ena", enas(), 3'b000);
            @(posedge clk);
            #1;
        end
        chk("t4_still_busy", busy, 1'b1);
        bus.nonalu_excpirq_flush_req_raw = 1'b0;
        #1;
        chk("t4_req_back", bus.brchmis_flush_req, 1'b1);
        chk("t4_ena", enas(), e.ena);
        @(posedge clk);
        #1;
        bus.brchmis_flush_ack = 1'b0;
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_flush_cnt", flush_cnt, 4'd4);

        // Correctly predicted branch and a plain commit retire without flush.
        commit(7'b1_000_111, 32'h5000, 32'h20, 1'b0, 32'h0, 32'h0, 3'b000);
        commit(7'b1_000_000, 32'h5004, 32'h0, 1'b0, 32'h0, 32'h0, 3'b000);
        chk("t5_flush_cnt", flush_cnt, 4'd4);
        chk("t5_mispred_cnt", mispred_cnt, 4'd2);

        // Drive flush_cnt to saturation, then one more.
        for (int i = 0; i < 11; i++) begin
            commit(7'b1_001_000, 32'h4000, 32'h0, 1'b1, 32'h4004, 32'h4004, 3'b100);
            ack_flush(0, 1'b0);
        end
        chk("t6_flush_cnt_full", flush_cnt, 4'hF);
        commit(7'b1_001_000, 32'h4000, 32'h0, 1'b1, 32'h4004, 32'h4004, 3'b100);
        ack_flush(0, 1'b0);
        chk("t6_flush_cnt_sat", flush_cnt, 4'hF);

        // Clear wins over a same-cycle increment.
        commit(7'b1_000_101, 32'h5000, 32'h8, 1'b1, 32'h5008, 32'h5008, 3'b000);
        ack_flush(0, 1'b1);
        chk("t6_flush_cnt_clr", flush_cnt, 4'h0);
        chk("t6_mispred_cnt_clr", mispred_cnt, 4'h0);
        chk("t6_flush_cnt2_clr", flush_cnt2, 4'h0);

        // Reset in REQ drops the request without an ena pulse.
        commit(7'b1_001_000, 32'h6000, 32'h0, 1'b1, 32'h6004, 32'h6004, 3'b100);
        e = sb.pop_front();
        chk("t7_flush_pc", bus.brchmis_flush_pc, e.pc);
        rst_n = 1'b0;
        bus.brchmis_flush_ack = 1'b1;
        #1;
        chk("t7_req", bus.brchmis_flush_req, 1'b0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_busy2", busy2, 1'b0);
        chk("t7_ena", enas(), 3'b000);
        chk("t7_flush_pc_rst", bus.brchmis_flush_pc, 32'h0);
        chk("t7_mispred2", mispred_cnt2, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.brchmis_flush_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("t7_idle_after", busy, 1'b0);
        chk("t7_ready_after", bus2.cmt_i_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_brchslv_reg.md
# ex_brchslv_reg

Registered, parametrised branch-resolve and flush-request stage in the EXU commit path. It accepts branch-class commits (bjp, fence.i, mret, dret) from the commit unit and decides whether a pipeline flush is needed. When one is, it captures the complete flush target PC into a register and holds a flush request until the IFU acknowledges it. It also keeps saturating mispredict and flush counters for performance monitoring.

## Interface
Parameters:
- PC_SIZE, 32, PC and target width.
- XLEN, 32, immediate width (≥ PC_SIZE).
- RVC_EN, 1, 1 = 16-bit instructions supported; 0 = sequential increment is always 4.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmt_i_valid / cmt_i_ready  in / out  1  commit handshake.
- cmt_i_rv32, cmt_i_dret, cmt_i_mret, cmt_i_fencei, cmt_i_bjp, cmt_i_bjp_prdt, cmt_i_bjp_rslv  in  1 each  instruction class and prediction fields.
- cmt_i_pc  in  PC_SIZE  PC of the committing instruction.
- cmt_i_imm  in  XLEN  branch offset.
- csr_epc_r, csr_dpc_r  in  PC_SIZE  mepc / dpc.
- nonalu_excpirq_flush_req_raw  in  1  higher-priority exception/IRQ flush pending.
- brchmis_flush_req / brchmis_flush_ack  out / in  1  flush handshake.
- brchmis_flush_pc  out  PC_SIZE  registered flush target.
- cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena  out  1  one-cycle enable pulses issued on flush handshake.
- cnt_clr  in  1  synchronous clear of both counters.
- mispred_cnt, flush_cnt  out  CNT_W  performance counters.
- busy  out  1  flush pending (state == REQ).

## Operation
- is_branch = bjp | fencei | mret | dret.
- need_flush = (bjp & (prdt ^ rslv)) | fencei | mret | dret.
- States: IDLE, REQ. Encoding: IDLE = 0, REQ = 1.
- cmt_i_ready = (state == IDLE) & (~is_branch | ~raw), where raw = nonalu_excpirq_flush_req_raw.
- Handshake in IDLE with is_branch & need_flush: capture flush_pc_r, type_r (mret/dret/fencei/mispred), go to REQ.
- Handshake in IDLE that needs no flush (non-branch, or correctly predicted bjp): retires in the same cycle; state stays IDLE; no register changes.
- Target priority: dret → csr_dpc_r; else mret → csr_epc_r; else fencei → pc+inc; else prdt=1 → pc+inc; else pc+imm[PC_SIZE-1:0].
  - inc = (cmt_i_rv32 | ~RVC_EN) ? 4 : 2.
  - Additions are modulo 2^PC_SIZE.
  - CSR values are sampled in the capture cycle only.
- In REQ:
  - brchmis_flush_req = ~raw.
  - An ack while raw=1 is ignored.
  - On req & ack: pulse the matching *_ena combinationally in that cycle, update counters, next state IDLE.
- Counters:
  - flush_cnt +1 on every acked flush.
  - mispred_cnt +1 on acked flushes of type mispred.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.

## Timing
- Reset values:
  - state IDLE; flush_pc_r 0; type_r 0.
  - brchmis_flush_req 0; all *_ena 0; counters 0; busy 0.
  - cmt_i_ready = 1 when raw=0.
- Capture on cycle N → brchmis_flush_req high from N+1.
- Ack in N+1 → ena pulse in N+1; next branch commit accepted at N+2 at the earliest.
- brchmis_flush_pc stays stable from N+1 until the handshake completes.
- Request is held indefinitely without ack; it drops only while raw=1 and reasserts when raw clears.
- Non-branch commits are blocked while in REQ, which preserves in-order commit.
- Reset asserted mid-REQ: the pending flush is dropped and no ena pulse is issued.

## Structure
- Shared package holds:
  - the state encoding;
  - INC4/INC2 constants;
  - the type_r one-hot encoding (MRET, DRET, FENCEI, MISPRED).
- One combinational sub-module, ex_brchslv_tgt: target-PC mux and adder, parametrised by PC_SIZE, XLEN, RVC_EN.
- The FSM, the capture registers and the two counter instances (a saturating counter with clear) live in the top module.

## Test plan
- bjp, prdt=0, rslv=1, pc=0x1000, imm=0x40:
  - flush_pc=0x1040 and req from N+1;
  - ack at N+3 → mispred_cnt=1, flush_cnt=1; no *_ena pulse.
- bjp, prdt=1, rslv=0, rv32=0, pc=0x2002 with RVC_EN=1 → flush_pc=0x2004; repeat with RVC_EN=0 → flush_pc=0x2006.
- mret and dret set together, epc=0x80, dpc=0x800 → flush_pc=0x800; cmt_dret_ena pulses on ack; cmt_mret_ena stays 0.
- In REQ, raw=1 for 3 cycles with ack held 1:
  - req=0 and no ena pulse during those cycles;
  - raw drops → req=1 and handshake completes.
- Correct prediction (prdt=rslv=1): ready=1, retires in the same cycle, no req, counters unchanged.
- Counter checks:
  - flush_cnt preset to all-ones with CNT_W=4, acked fencei → stays 0xF and cmt_fencei_ena pulses;
  - cnt_clr in the same cycle → 0.
